// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with write acknowledge, overflow/underflow
// indication and full/almostfull/empty/almostempty status flags.
// Read data is registered: a word appears on data_out one cycle after the
// edge that admits the read.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  wr_adm;
  logic                  rd_adm;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_next;

  // Status flags decode straight from the occupancy count.
  assign full        = (count == CNT_FULL);
  assign almostfull  = (count == CNT_AFULL);
  assign empty       = (count == CNT_ZERO);
  assign almostempty = (count == CNT_ONE);

  // Requests are admitted against the pre-edge state; a full FIFO can still
  // read and an empty FIFO can still write in the same cycle.
  assign wr_adm = wr_en & ~full;
  assign rd_adm = rd_en & ~empty;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  always_comb begin
    wr_ptr_next = wr_ptr + PTR_W'(1);
    rd_ptr_next = rd_ptr + PTR_W'(1);
    if (wr_ptr == PTR_LAST) wr_ptr_next = '0;
    if (rd_ptr == PTR_LAST) rd_ptr_next = '0;
  end

  // Storage array: written on admitted writes only, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_adm && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy count, registered read data and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_adm;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;

      if (wr_adm) begin
        wr_ptr <= wr_ptr_next;
      end

      if (rd_adm) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr_next;
      end

      if (wr_adm && !rd_adm) begin
        count <= count + CNT_ONE;
      end else if (rd_adm && !wr_adm) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule
